// File: rtl/sv_bus_arbiter_pkg.sv
// Shared types and phase constants for the system bus arbiter and its
// clock-enable plumbing.
package sv_pkg;

  typedef enum logic [1:0] {
    OWN_CPU  = 2'd0,
    OWN_VDMA = 2'd1,
    OWN_ADMA = 2'd2
  } bus_owner_t;

  localparam logic [1:0] DIV_PHI1 = 2'd0;
  localparam logic [1:0] DIV_PHI2 = 2'd2;
  localparam logic [1:0] DIV_ARB  = 2'd3;

endpackage

// File: rtl/sv_bus_arbiter_if.sv
// Request/grant/bus bundle between the arbiter (master) and the three
// bus clients plus the memory decode (slave).
interface sv_bus_arbiter_if #(
  parameter int BURST_W = 8
) ();

  logic               phi1;
  logic               phi2;
  logic               adma_req;
  logic [15:0]        adma_addr;
  logic               vdma_req;
  logic [15:0]        vdma_addr;
  logic               vdma_we;
  logic [15:0]        cpu_addr;
  logic               cpu_we;
  logic               gnt_adma;
  logic               gnt_vdma;
  logic               gnt_cpu;
  logic               cpu_ce;
  logic [15:0]        bus_addr;
  logic               bus_we;
  logic [BURST_W-1:0] burst_cnt;

  modport master (
    input  adma_req, adma_addr, vdma_req, vdma_addr, vdma_we, cpu_addr, cpu_we,
    output phi1, phi2, gnt_adma, gnt_vdma, gnt_cpu, cpu_ce, bus_addr, bus_we,
           burst_cnt
  );

  modport slave (
    output adma_req, adma_addr, vdma_req, vdma_addr, vdma_we, cpu_addr, cpu_we,
    input  phi1, phi2, gnt_adma, gnt_vdma, gnt_cpu, cpu_ce, bus_addr, bus_we,
           burst_cnt
  );

endinterface

// File: rtl/sv_bus_arbiter_phase.sv
// Free-running 4-phase slot divider; decodes phi1/phi2 and the end-of-slot
// arbitration tick. Also used by the lcd/audio clock-enable logic.
module sv_phase_gen
  import sv_pkg::*;
(
  input  logic clk_sys,
  input  logic reset,
  output logic phi1_o,
  output logic phi2_o,
  output logic arb_tick_o
);

  logic [1:0] div_q;
  logic [1:0] div_d;

  // next slot phase
  always_comb begin
    div_d = div_q + 2'd1;
  end

  // slot phase register
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      div_q <= DIV_PHI1;
    end else begin
      div_q <= div_d;
    end
  end

  assign phi1_o     = (div_q == DIV_PHI1);
  assign phi2_o     = (div_q == DIV_PHI2);
  assign arb_tick_o = (div_q == DIV_ARB);

endmodule

// File: rtl/sv_bus_arbiter.sv
// Slot-based owner of the shared system bus: ADMA > VDMA > CPU, with an
// optional VDMA burst guard that forces a CPU slot after N VDMA slots.
module sv_bus_arbiter
  import sv_pkg::*;
#(
  parameter int VDMA_MAX_BURST = 0,
  parameter int BURST_W        = 8
) (
  input  logic              clk_sys,
  input  logic              reset,
  sv_bus_arbiter_if.master  bus
);

  localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);
  localparam logic [BURST_W-1:0] BURST_SAT = {BURST_W{1'b1}};
  localparam logic [BURST_W-1:0] GUARD_LIM = BURST_W'(VDMA_MAX_BURST);
  localparam bit                 GUARD_EN  = (VDMA_MAX_BURST != 0);

  logic               phi1;
  logic               phi2;
  logic               arb_tick;
  bus_owner_t         owner_q, owner_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic               vdma_we_q, vdma_we_d;
  logic               guard;

  sv_phase_gen u_phase (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .phi1_o     (phi1),
    .phi2_o     (phi2),
    .arb_tick_o (arb_tick)
  );

  assign guard = GUARD_EN && (burst_q == GUARD_LIM);

  // end-of-slot decision; everything holds mid-slot
  always_comb begin
    owner_d   = owner_q;
    burst_d   = burst_q;
    vdma_we_d = vdma_we_q;
    if (arb_tick) begin
      vdma_we_d = bus.vdma_we;
      if (bus.adma_req) begin
        owner_d = OWN_ADMA;
      end else if (bus.vdma_req && !guard) begin
        owner_d = OWN_VDMA;
        if (burst_q != BURST_SAT) begin
          burst_d = burst_q + BURST_ONE;
        end else begin
          burst_d = burst_q;
        end
      end else begin
        owner_d = OWN_CPU;
        burst_d = '0;
      end
    end else begin
      owner_d = owner_q;
    end
  end

  // owner, burst count and sampled VDMA direction
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      owner_q   <= OWN_CPU;
      burst_q   <= '0;
      vdma_we_q <= 1'b0;
    end else begin
      owner_q   <= owner_d;
      burst_q   <= burst_d;
      vdma_we_q <= vdma_we_d;
    end
  end

  // address/write mux of the current owner
  always_comb begin
    bus.bus_addr = bus.cpu_addr;
    bus.bus_we   = bus.cpu_we;
    case (owner_q)
      OWN_ADMA: begin
        bus.bus_addr = bus.adma_addr;
        bus.bus_we   = 1'b0;
      end
      OWN_VDMA: begin
        bus.bus_addr = bus.vdma_addr;
        bus.bus_we   = vdma_we_q;
      end
      OWN_CPU: begin
        bus.bus_addr = bus.cpu_addr;
        bus.bus_we   = bus.cpu_we;
      end
      default: begin
        bus.bus_addr = bus.cpu_addr;
        bus.bus_we   = bus.cpu_we;
      end
    endcase
  end

  // the unused owner encoding falls back to the CPU so one grant is always high
  assign bus.gnt_adma  = (owner_q == OWN_ADMA);
  assign bus.gnt_vdma  = (owner_q == OWN_VDMA);
  assign bus.gnt_cpu   = !((owner_q == OWN_ADMA) || (owner_q == OWN_VDMA));
  assign bus.cpu_ce    = phi1 && bus.gnt_cpu;
  assign bus.phi1      = phi1;
  assign bus.phi2      = phi2;
  assign bus.burst_cnt = burst_q;

endmodule

// File: tb/tb_sv_bus_arbiter.sv
// Directed bench for sv_bus_arbiter: one instance without the burst guard,
// one with VDMA_MAX_BURST=2.
module tb_sv_bus_arbiter;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  int   n_chk   = 0;
  int   n_pass  = 0;
  logic [1:0] bdiv = 2'd0;

  always #5 clk_sys = ~clk_sys;

  sv_bus_arbiter_if #(.BURST_W(8)) if0 ();
  sv_bus_arbiter_if #(.BURST_W(8)) if1 ();

  sv_bus_arbiter #(.VDMA_MAX_BURST(0), .BURST_W(8)) u_dut0 (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (if0)
  );

  sv_bus_arbiter #(.VDMA_MAX_BURST(2), .BURST_W(8)) u_dut1 (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (if1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (obs === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // one clock; bench tracks the slot phase itself and checks strobes/one-hot
  task automatic tick();
    @(posedge clk_sys);
    #1;
    if (reset) bdiv = 2'd0;
    else       bdiv = bdiv + 2'd1;
    chk("phi1_0", 32'(if0.phi1), 32'(bdiv == 2'd0));
    chk("phi2_0", 32'(if0.phi2), 32'(bdiv == 2'd2));
    chk("phi1_1", 32'(if1.phi1), 32'(bdiv == 2'd0));
    chk("onehot0", 32'($countones({if0.gnt_adma, if0.gnt_vdma, if0.gnt_cpu})), 32'd1);
    chk("onehot1", 32'($countones({if1.gnt_adma, if1.gnt_vdma, if1.gnt_cpu})), 32'd1);
  endtask

  task automatic wait_div(input logic [1:0] d);
    for (int k = 0; k < 4 && bdiv != d; k++) tick();
  endtask

  logic       exp_v [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [7:0] exp_b [6] = '{8'd1, 8'd2, 8'd0, 8'd1, 8'd2, 8'd0};

  initial begin
    if0.adma_req = 1'b0; if0.adma_addr = 16'h0000; if0.vdma_req = 1'b0;
    if0.vdma_addr = 16'h0000; if0.vdma_we = 1'b0; if0.cpu_addr = 16'h0000; if0.cpu_we = 1'b0;
    if1.adma_req = 1'b0; if1.adma_addr = 16'h0000; if1.vdma_req = 1'b0;
    if1.vdma_addr = 16'h0000; if1.vdma_we = 1'b0; if1.cpu_addr = 16'h0000; if1.cpu_we = 1'b0;

    // reset state
    tick();
    tick();
    chk("rst_gnt_cpu", 32'(if0.gnt_cpu), 32'd1);
    chk("rst_gnt_vdma", 32'(if0.gnt_vdma), 32'd0);
    chk("rst_gnt_adma", 32'(if0.gnt_adma), 32'd0);
    chk("rst_burst", 32'(if0.burst_cnt), 32'd0);
    chk("rst_gnt_cpu1", 32'(if1.gnt_cpu), 32'd1);
    reset = 1'b0;

    // idle: CPU owns the bus, cpu_ce every 4th clock
    for (int i = 0; i < 16; i++) begin
      if0.cpu_addr = 16'h1000 + 16'(i);
      #1;
      chk("idle_gnt_cpu", 32'(if0.gnt_cpu), 32'd1);
      chk("idle_cpu_ce", 32'(if0.cpu_ce), 32'((i % 4) == 0));
      chk("idle_addr", 32'(if0.bus_addr), 32'h1000 + 32'(i));
      tick();
    end

    // VDMA burst of 3 slots, no guard; vdma_we change mid-slot is deferred
    tick();
    if0.vdma_req = 1'b1; if0.vdma_we = 1'b1; if0.vdma_addr = 16'hBEEF;
    tick(); tick(); tick();
    for (int j = 0; j < 12; j++) begin
      if (j == 1) if0.vdma_we = 1'b0;
      if (j == 8) if0.vdma_req = 1'b0;
      #1;
      chk("vb_gnt_vdma", 32'(if0.gnt_vdma), 32'd1);
      chk("vb_cpu_ce", 32'(if0.cpu_ce), 32'd0);
      chk("vb_burst", 32'(if0.burst_cnt), 32'(j / 4 + 1));
      chk("vb_addr", 32'(if0.bus_addr), 32'hBEEF);
      chk("vb_we", 32'(if0.bus_we), 32'(j < 4));
      tick();
    end
    chk("vb_end_gnt_cpu", 32'(if0.gnt_cpu), 32'd1);
    chk("vb_end_burst", 32'(if0.burst_cnt), 32'd0);
    chk("vb_end_cpu_ce", 32'(if0.cpu_ce), 32'd1);

    // guard = 2 on instance 1
    tick();
    if1.vdma_req = 1'b1; if1.vdma_addr = 16'h5A5A;
    for (int s = 0; s < 6; s++) begin
      wait_div(2'd0);
      chk("gd_gnt_vdma", 32'(if1.gnt_vdma), 32'(exp_v[s]));
      chk("gd_gnt_cpu", 32'(if1.gnt_cpu), 32'(!exp_v[s]));
      chk("gd_burst", 32'(if1.burst_cnt), 32'(exp_b[s]));
      tick();
    end
    if1.vdma_req = 1'b0;

    // ADMA beats VDMA, burst count preserved across the ADMA slot
    if0.vdma_req = 1'b1; if0.vdma_we = 1'b1;
    wait_div(2'd0);
    chk("ad_pre_burst", 32'(if0.burst_cnt), 32'd1);
    wait_div(2'd3);
    if0.adma_req = 1'b1; if0.adma_addr = 16'hA0A0; if0.cpu_we = 1'b1; if0.cpu_addr = 16'h1234;
    tick();
    chk("ad_gnt_adma", 32'(if0.gnt_adma), 32'd1);
    chk("ad_bus_we", 32'(if0.bus_we), 32'd0);
    chk("ad_addr", 32'(if0.bus_addr), 32'hA0A0);
    chk("ad_burst", 32'(if0.burst_cnt), 32'd1);
    chk("ad_cpu_ce", 32'(if0.cpu_ce), 32'd0);
    tick();
    if0.adma_req = 1'b0;
    wait_div(2'd0);
    chk("ad_then_vdma", 32'(if0.gnt_vdma), 32'd1);
    chk("ad_then_burst", 32'(if0.burst_cnt), 32'd2);
    chk("ad_then_we", 32'(if0.bus_we), 32'd1);
    tick();
    if0.vdma_req = 1'b0; if0.cpu_we = 1'b0;
    wait_div(2'd0);
    chk("ad_cpu_back", 32'(if0.gnt_cpu), 32'd1);
    chk("ad_cpu_burst", 32'(if0.burst_cnt), 32'd0);
    chk("ad_cpu_addr", 32'(if0.bus_addr), 32'h1234);

    // single-clock request pulses: div==1 ignored, div==3 gives one slot
    tick();
    if0.vdma_req = 1'b1;
    tick();
    if0.vdma_req = 1'b0;
    wait_div(2'd0);
    chk("p1_gnt_cpu", 32'(if0.gnt_cpu), 32'd1);
    chk("p1_cpu_ce", 32'(if0.cpu_ce), 32'd1);
    wait_div(2'd3);
    if0.vdma_req = 1'b1;
    tick();
    if0.vdma_req = 1'b0;
    chk("p3_gnt_vdma", 32'(if0.gnt_vdma), 32'd1);
    chk("p3_burst", 32'(if0.burst_cnt), 32'd1);
    tick();
    wait_div(2'd0);
    chk("p3_after_cpu", 32'(if0.gnt_cpu), 32'd1);
    chk("p3_after_burst", 32'(if0.burst_cnt), 32'd0);

    // reset mid VDMA slot with request held
    tick();
    if0.vdma_req = 1'b1;
    wait_div(2'd0);
    chk("rs_pre_vdma", 32'(if0.gnt_vdma), 32'd1);
    wait_div(2'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rs_gnt_cpu", 32'(if0.gnt_cpu), 32'd1);
    chk("rs_burst", 32'(if0.burst_cnt), 32'd0);
    chk("rs_cpu_ce", 32'(if0.cpu_ce), 32'd1);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("rs_hold_cpu", 32'(if0.gnt_cpu), 32'd1);
    end
    tick();
    chk("rs_vdma_again", 32'(if0.gnt_vdma), 32'd1);
    chk("rs_vdma_burst", 32'(if0.burst_cnt), 32'd1);
    if0.vdma_req = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sv_bus_arbiter.md
Name: sv_bus_arbiter

Overview:
- Owns the shared 16-bit system address bus (WRAM/VRAM/ROM/sys registers).
- Shares it between three masters: audio DMA (ADMA), video DMA (VDMA) and the 65C02.
- Generates the phi1/phi2 phase strobes and grants the bus one 4-clock slot at a time.
- Produces the CPU clock enable, so the CPU halts while a DMA owns the bus.
- Replaces the ad-hoc address/write muxing and the cpu_rdy gating at the top level.

Parameters:
- VDMA_MAX_BURST, 0: maximum consecutive VDMA slots before one CPU slot is forced. 0 disables the guard (pure priority).
- BURST_W, 8: width of the VDMA burst counter. VDMA_MAX_BURST must be < 2**BURST_W.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high
- phi1  out  1  strobe, high when div==0
- phi2  out  1  strobe, high when div==2
- adma_req  in  1  audio DMA wants next slot (read only)
- adma_addr  in  16  audio DMA address
- vdma_req  in  1  video DMA wants next slot
- vdma_addr  in  16  video DMA system-side address
- vdma_we  in  1  VDMA slot writes system memory (VRAM->RAM direction)
- cpu_addr  in  16  CPU address
- cpu_we  in  1  CPU write (inverse of rw_n)
- gnt_adma  out  1  current slot owned by ADMA
- gnt_vdma  out  1  current slot owned by VDMA
- gnt_cpu  out  1  current slot owned by CPU
- cpu_ce  out  1  CPU clock enable, equals phi1 & gnt_cpu
- bus_addr  out  16  muxed address of current owner
- bus_we  out  1  muxed write of current owner; 0 during ADMA slots
- burst_cnt  out  BURST_W  consecutive VDMA slots granted (debug/verification)

Behaviour:
- Free-running 2-bit div counter increments every clk_sys.
  - phi1 and phi2 are combinational decodes of div.
  - A slot is div 0..3.
- Arbitration happens at the registered edge where div==3 (end of slot). The new one-hot grant is valid from div==0 through div==3 of the next slot.
- Grant is stable for the whole slot. A request change mid-slot has no effect until the next div==3.
- adma_req, vdma_req and vdma_we are sampled only at div==3.
- Priority at each decision, first match wins:
  1. adma_req=1: grant ADMA. burst_cnt holds.
  2. vdma_req=1 and guard inactive: grant VDMA. burst_cnt increments, saturating at 2**BURST_W-1.
  3. Otherwise: grant CPU. burst_cnt clears to 0.
- Guard active means VDMA_MAX_BURST!=0 and burst_cnt==VDMA_MAX_BURST. The forced CPU slot clears burst_cnt, so VDMA resumes on the following decision.
- The CPU always wants the bus; no cpu_req exists.
- bus_addr and bus_we are combinational muxes driven by the registered grant:
  - ADMA: adma_addr, we=0
  - VDMA: vdma_addr, we=vdma_we
  - CPU: cpu_addr, cpu_we
- cpu_ce pulses exactly once per CPU slot, at div==0. A DMA slot delays the CPU by exactly 4 clk_sys with no lost CPU cycle.
- Exactly one gnt_* is high at all times, including in reset.
- Simultaneous adma_req and vdma_req: ADMA wins. VDMA is served on the next decision if still requested, and its burst count is preserved across the ADMA slot.
- Reset (synchronous, any cycle, including mid-slot):
  - div=0, gnt_cpu=1, gnt_adma=0, gnt_vdma=0, burst_cnt=0.
  - Hence phi1=1 and cpu_ce=1 in the first cycle after reset deasserts.
  - Any pending request is dropped.
- No combinational path from any *_req to any gnt_* or cpu_ce.

Decomposition:
- Shared package sv_pkg:
  - enum bus_owner_t {OWN_CPU, OWN_VDMA, OWN_ADMA}
  - localparams DIV_PHI1=2'd0, DIV_PHI2=2'd2, DIV_ARB=2'd3
- The one-hot grants are decoded from a registered bus_owner_t.
- One natural sub-module: sv_phase_gen, holding the div counter and the phi1/phi2/arb_tick decode. It is reusable by the lcd/audio clock-enable plumbing.

Test Plan:
- No requests, 16 clocks after reset -> gnt_cpu constant 1; cpu_ce high at clocks 0, 4, 8, 12 only; bus_addr==cpu_addr throughout.
- vdma_req=1 raised at div==1 and held 3 slots, VDMA_MAX_BURST=0 -> gnt_vdma from the next div==0 for 12 clocks; no cpu_ce in that window; burst_cnt steps 1, 2, 3, then clears to 0 on the following CPU slot.
- VDMA_MAX_BURST=2, vdma_req held high -> owner sequence VDMA, VDMA, CPU, VDMA, VDMA, CPU; burst_cnt 1, 2, 0, 1, 2, 0.
- adma_req and vdma_req both asserted at div==3, adma_req dropped after one slot -> ADMA slot (bus_we=0 even with cpu_we=1), then VDMA slot; burst_cnt unchanged across the ADMA slot.
- vdma_req pulsed 1 clock at div==1 only -> not sampled; CPU keeps the bus. Same pulse at div==3 -> exactly one VDMA slot.
- reset asserted at div==2 of a VDMA slot, requests held -> next cycle div==0, gnt_cpu=1, burst_cnt=0; VDMA is granted again starting 4 clocks later.
